// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix solver and its residual checker.
package matrix_pkg;

  localparam int DATA_W = 20;

  typedef enum logic [2:0] {
    OP_GET_N  = 3'b000,
    OP_READ_Y = 3'b001,
    OP_READ_A = 3'b010,
    OP_READ_X = 3'b011,
    OP_NOP    = 3'b110
  } opcode_e;

  // S_WAIT_N is the cycle in which the GET_N response arrives and n is decided on.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_N  = 3'd1,
    S_WAIT_N = 3'd2,
    S_REQ_Y  = 3'd3,
    S_REQ_A  = 3'd4,
    S_REQ_X  = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/resid_mac.sv
// Residual multiply-subtract datapath: acc = y, then acc -= A*x per column.
module resid_mac #(
  parameter int DATA_W = matrix_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              cap_a_i,
  input  logic              sub_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] residual_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] prod_s;

  // Products and differences wrap at DATA_W bits.
  assign prod_s     = a_q * data_i;
  assign residual_o = acc_q - prod_s;

  // Accumulator and coefficient next-state selection.
  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    if (load_i) begin
      acc_d = data_i;
    end else if (sub_i) begin
      acc_d = residual_o;
    end else begin
      acc_d = acc_q;
    end
    if (cap_a_i) begin
      a_d = data_i;
    end else begin
      a_d = a_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {DATA_W{1'b0}};
      a_q   <= {DATA_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
    end
  end

endmodule

// File: rtl/matrix_residual_check.sv
// Verifies an upper-triangular solve (y = A*x) row by row via the memory command port.
// Optional feature macro RESID_MAXERR_EN: track the largest |residual| on max_err.
module matrix_residual_check #(
  parameter int DATA_W = matrix_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        opcode,
  output logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] j,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] err_count,
  output logic [DATA_W-1:0] first_err_row,
  output logic [DATA_W-1:0] max_err
);
  import matrix_pkg::*;

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d, row_q, row_d, col_q, col_d;
  logic [2:0]        opcode_q, opcode_d, last_op_q;
  logic [DATA_W-1:0] i_q, i_d, j_q, j_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [DATA_W-1:0] err_q, err_d, first_q, first_d;
  logic [DATA_W-1:0] residual_s;
  logic              run_start_s, row_err_s, last_col_s, last_row_s;

  assign run_start_s = (state_q == S_IDLE) && start;
  assign last_col_s  = (col_q == (n_q - ONE));
  assign last_row_s  = (row_q == (n_q - ONE));
  assign row_err_s   = (state_q == S_CHECK) && (residual_s != ZERO);

  // State and loop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= ZERO;
      row_q   <= ZERO;
      col_q   <= ZERO;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ_N;
        else       state_d = S_IDLE;
      end
      S_REQ_N:  state_d = S_WAIT_N;
      S_WAIT_N: begin
        n_d   = in_data;
        row_d = ZERO;
        if (in_data == ZERO) state_d = S_DONE;
        else                 state_d = S_REQ_Y;
      end
      S_REQ_Y: begin
        state_d = S_REQ_A;
        col_d   = row_q;
      end
      S_REQ_A:  state_d = S_REQ_X;
      S_REQ_X: begin
        if (last_col_s) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_REQ_A;
          col_d   = col_q + ONE;
        end
      end
      S_CHECK: begin
        if (last_row_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ_Y;
          row_d   = row_q + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commands are decoded from the next state so they leave a register.
  always_comb begin
    opcode_d = OP_NOP;
    i_d      = ZERO;
    j_d      = ZERO;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_REQ_N: opcode_d = OP_GET_N;
      S_REQ_Y: begin
        opcode_d = OP_READ_Y;
        i_d      = row_d;
      end
      S_REQ_A: begin
        opcode_d = OP_READ_A;
        i_d      = row_d;
        j_d      = col_d;
      end
      S_REQ_X: begin
        opcode_d = OP_READ_X;
        i_d      = col_d;
      end
      default: opcode_d = OP_NOP;
    endcase
  end

  // Run result bookkeeping; results hold until the next accepted start.
  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (run_start_s) begin
      err_d   = ZERO;
      first_d = ZERO;
    end else if (row_err_s) begin
      err_d = err_q + ONE;
      if (err_q == ZERO) first_d = row_q;
      else               first_d = first_q;
    end else begin
      err_d = err_q;
    end
    if (run_start_s)             pass_d = 1'b0;
    else if (state_d == S_DONE)  pass_d = (err_d == ZERO);
    else                         pass_d = pass_q;
  end

  // Output and result registers; last_op_q tags what in_data currently carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= OP_NOP;
      last_op_q <= OP_NOP;
      i_q       <= ZERO;
      j_q       <= ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= ZERO;
      first_q   <= ZERO;
    end else begin
      opcode_q  <= opcode_d;
      last_op_q <= opcode_q;
      i_q       <= i_d;
      j_q       <= j_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  resid_mac #(.DATA_W(DATA_W)) u_resid_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (last_op_q == OP_READ_Y),
    .cap_a_i    (last_op_q == OP_READ_A),
    .sub_i      (last_op_q == OP_READ_X),
    .data_i     (in_data),
    .residual_o (residual_s)
  );

`ifdef RESID_MAXERR_EN
  logic [DATA_W-1:0] max_q, max_d, abs_s;

  assign abs_s = residual_s[DATA_W-1] ? (ZERO - residual_s) : residual_s;

  // Largest unsigned |residual| of the current run.
  always_comb begin
    if (run_start_s)                                max_d = ZERO;
    else if ((state_q == S_CHECK) && (abs_s > max_q)) max_d = abs_s;
    else                                            max_d = max_q;
  end

  // Max-error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= ZERO;
    else        max_q <= max_d;
  end

  assign max_err = max_q;
`else
  assign max_err = ZERO;
`endif

  assign opcode        = opcode_q;
  assign i             = i_q;
  assign j             = j_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_row = first_q;

endmodule
